// File: rtl/core_mem_arbiter_if.sv
// Bundles the data port, fetch port and shared memory bus of the arbiter.
// slave is the arbiter's view; master is the cores-plus-memory side.
interface core_mem_arbiter_if #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64
);
    localparam int STRB_W = MEM_DATA_W / 8;

    logic                  d_req;
    logic [MEM_ADDR_W-1:0] d_addr;
    logic                  d_wen;
    logic [STRB_W-1:0]     d_strb;
    logic [MEM_DATA_W-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_err;
    logic [MEM_DATA_W-1:0] d_rdata;

    logic                  i_req;
    logic [MEM_ADDR_W-1:0] i_addr;
    logic                  i_gnt;
    logic                  i_err;
    logic [MEM_DATA_W-1:0] i_rdata;

    logic                  mem_req;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_wen;
    logic [STRB_W-1:0]     mem_strb;
    logic [MEM_DATA_W-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_err;
    logic [MEM_DATA_W-1:0] mem_rdata;

    modport slave (
        input  d_req, d_addr, d_wen, d_strb, d_wdata,
        output d_gnt, d_err, d_rdata,
        input  i_req, i_addr,
        output i_gnt, i_err, i_rdata,
        output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
        input  mem_gnt, mem_err, mem_rdata
    );

    modport master (
        output d_req, d_addr, d_wen, d_strb, d_wdata,
        input  d_gnt, d_err, d_rdata,
        output i_req, i_addr,
        input  i_gnt, i_err, i_rdata,
        input  mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
        output mem_gnt, mem_err, mem_rdata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Two-port (LSU data / instruction fetch) arbiter onto one memory bus:
// zero-latency forwarding from IDLE, round-robin on contention, ownership until gnt or timeout.
module core_mem_arbiter #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    core_mem_arbiter_if.slave  bus
);
    localparam int          STRB_W = MEM_DATA_W / 8;
    localparam logic [9:0]  TMO    = 10'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OWN_D, OWN_I} state_e;

    state_e     state_q, state_d;
    logic       last_i_q, last_i_d;
    logic [9:0] cnt_q, cnt_d;

    logic sel_d, sel_i, tmo, fwd;
    logic [MEM_ADDR_W-1:0] addr_mux;
    logic [STRB_W-1:0]     strb_mux;
    logic [MEM_DATA_W-1:0] wdata_mux;

    // Owner selection; reset forces nothing selected so all outputs idle.
    always_comb begin
        sel_d = 1'b0;
        sel_i = 1'b0;
        case (state_q)
            IDLE: begin
                sel_d = bus.d_req && (!bus.i_req || last_i_q);
                sel_i = bus.i_req && !sel_d;
            end
            OWN_D:   sel_d = 1'b1;
            OWN_I:   sel_i = 1'b1;
            default: ;
        endcase
        if (!g_resetn) begin
            sel_d = 1'b0;
            sel_i = 1'b0;
        end
    end

    assign tmo = g_resetn && (state_q != IDLE) && (cnt_q == TMO) && !bus.mem_gnt;
    assign fwd = (sel_d || sel_i) && !tmo;

    always_comb begin
        addr_mux  = '0;
        strb_mux  = '0;
        wdata_mux = '0;
        if (fwd && sel_d) begin
            addr_mux  = bus.d_addr;
            strb_mux  = bus.d_strb;
            wdata_mux = bus.d_wdata;
        end else if (fwd && sel_i) begin
            addr_mux  = bus.i_addr;
        end
    end

    assign bus.mem_req   = fwd;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wen   = fwd && sel_d && bus.d_wen;
    assign bus.mem_strb  = strb_mux;
    assign bus.mem_wdata = wdata_mux;

    // A timeout fabricates an error response; a real gnt in that cycle wins.
    assign bus.d_gnt   = sel_d && (bus.mem_gnt || tmo);
    assign bus.d_err   = sel_d && (tmo || (bus.mem_gnt && bus.mem_err));
    assign bus.d_rdata = (sel_d && !tmo) ? bus.mem_rdata : '0;
    assign bus.i_gnt   = sel_i && (bus.mem_gnt || tmo);
    assign bus.i_err   = sel_i && (tmo || (bus.mem_gnt && bus.mem_err));
    assign bus.i_rdata = (sel_i && !tmo) ? bus.mem_rdata : '0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_i_d = last_i_q;
        case (state_q)
            IDLE: begin
                if (fwd) begin
                    last_i_d = sel_i;
                    if (!bus.mem_gnt) begin
                        state_d = sel_d ? OWN_D : OWN_I;
                        cnt_d   = '0;
                    end
                end
            end
            OWN_D, OWN_I: begin
                if (bus.mem_gnt || tmo) state_d = IDLE;
                else                    cnt_d   = cnt_q + 10'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // last_i resets to 1 so the data port wins the first contention.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_i_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_i_q <= last_i_d;
        end
    end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed vector table plus hand sequences for timeout and mid-transaction reset.
module tb_core_mem_arbiter;
    localparam logic [63:0] DA = 64'h1000;
    localparam logic [63:0] IA = 64'h80;
    localparam logic [63:0] WD = 64'hCAFE;
    localparam logic [7:0]  ST = 8'h0F;

    logic g_clk = 1'b0;
    logic g_resetn;
    int   errors = 0;
    int   checks = 0;

    always #5 g_clk = ~g_clk;

    core_mem_arbiter_if #(.MEM_ADDR_W(64), .MEM_DATA_W(64)) bus ();

    core_mem_arbiter #(.MEM_ADDR_W(64), .MEM_DATA_W(64), .TIMEOUT(4)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus.slave)
    );

    // ebus: 0 = bus idle, 1 = data port on bus, 2 = fetch port on bus
    typedef struct {
        logic        rst_n, dreq, dwen, ireq, mgnt, merr;
        logic [63:0] mrd;
        logic [1:0]  ebus;
        logic        edg, ede, eig, eie;
        logic [63:0] erdd, erdi;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic dq, logic dw, logic iq, logic mg, logic me,
                                logic [63:0] mr, logic [1:0] eb, logic edg, logic ede,
                                logic eig, logic eie, logic [63:0] erdd, logic [63:0] erdi);
        vec_t v;
        v.rst_n = r;  v.dreq = dq; v.dwen = dw; v.ireq = iq; v.mgnt = mg; v.merr = me;
        v.mrd = mr;   v.ebus = eb; v.edg = edg; v.ede = ede; v.eig = eig; v.eie = eie;
        v.erdd = erdd; v.erdi = erdi;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        logic [63:0] ea, es, ew;
        logic        ewen;
        int          n;

        bus.d_addr = DA; bus.d_strb = ST; bus.d_wdata = WD; bus.i_addr = IA;
        bus.d_req = 0; bus.d_wen = 0; bus.i_req = 0;
        bus.mem_gnt = 0; bus.mem_err = 0; bus.mem_rdata = '0;
        g_resetn = 0;

        //           rst dq dw iq mg me mrd       bus dg de ig ie rdd       rdi
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 64'h0,    0, 0, 0, 0, 0, 64'h0,    64'h0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 64'h0,    0, 0, 0, 0, 0, 64'h0,    64'h0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 64'h11,   1, 1, 0, 0, 0, 64'h11,   64'h0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 64'h22,   2, 0, 0, 1, 0, 64'h0,    64'h22));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 64'h33,   1, 1, 0, 0, 0, 64'h33,   64'h0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 64'h44,   2, 0, 0, 1, 0, 64'h0,    64'h44));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 64'h0,    2, 0, 0, 0, 0, 64'h0,    64'h0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 64'h0,    2, 0, 0, 0, 0, 64'h0,    64'h0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 64'h0,    2, 0, 0, 0, 0, 64'h0,    64'h0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 64'hDEAD, 2, 0, 0, 1, 0, 64'h0,    64'hDEAD));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 64'h0,    1, 0, 0, 0, 0, 64'h0,    64'h0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, 64'h0,    1, 0, 0, 0, 0, 64'h0,    64'h0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 64'h55,   1, 1, 0, 0, 0, 64'h55,   64'h0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 64'h66,   2, 0, 0, 1, 0, 64'h0,    64'h66));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 64'h77,   2, 0, 0, 1, 1, 64'h0,    64'h77));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1, 64'h88,   0, 0, 0, 0, 0, 64'h0,    64'h0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1, 64'h99,   1, 1, 1, 0, 0, 64'h99,   64'h0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 0, 64'hAA,   2, 0, 0, 1, 0, 64'h0,    64'hAA));

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            g_resetn = v.rst_n; bus.d_req = v.dreq; bus.d_wen = v.dwen; bus.i_req = v.ireq;
            bus.mem_gnt = v.mgnt; bus.mem_err = v.merr; bus.mem_rdata = v.mrd;
            ea = '0; es = '0; ew = '0; ewen = 1'b0;
            if (v.ebus == 2'd1) begin ea = DA; es = {56'h0, ST}; ew = WD; ewen = v.dwen; end
            if (v.ebus == 2'd2) ea = IA;
            @(negedge g_clk);
            chk($sformatf("r%0d mem_req", k),   {63'h0, bus.mem_req},  {63'h0, v.ebus != 2'd0});
            chk($sformatf("r%0d mem_addr", k),  bus.mem_addr,          ea);
            chk($sformatf("r%0d mem_wen", k),   {63'h0, bus.mem_wen},  {63'h0, ewen});
            chk($sformatf("r%0d mem_strb", k),  {56'h0, bus.mem_strb}, es);
            chk($sformatf("r%0d mem_wdata", k), bus.mem_wdata,         ew);
            chk($sformatf("r%0d d_gnt", k),     {63'h0, bus.d_gnt},    {63'h0, v.edg});
            chk($sformatf("r%0d d_err", k),     {63'h0, bus.d_err},    {63'h0, v.ede});
            chk($sformatf("r%0d d_rdata", k),   bus.d_rdata,           v.erdd);
            chk($sformatf("r%0d i_gnt", k),     {63'h0, bus.i_gnt},    {63'h0, v.eig});
            chk($sformatf("r%0d i_err", k),     {63'h0, bus.i_err},    {63'h0, v.eie});
            chk($sformatf("r%0d i_rdata", k),   bus.i_rdata,           v.erdi);
            step();
        end

        // Timeout: no mem_gnt, fetch requests meanwhile and must be ignored.
        bus.d_req = 1; bus.d_wen = 0; bus.i_req = 0;
        bus.mem_gnt = 0; bus.mem_err = 0; bus.mem_rdata = 64'h99;
        n = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge g_clk);
            if (bus.d_gnt) begin n = c; break; end
            chk("to mem_req held", {63'h0, bus.mem_req}, 64'h1);
            chk("to i_gnt idle", {63'h0, bus.i_gnt}, 64'h0);
            step();
            if (c == 1) bus.i_req = 1;
        end
        chk("to gnt cycle", 64'(n), 64'd5);
        if (n >= 0) begin
            chk("to d_err", {63'h0, bus.d_err}, 64'h1);
            chk("to mem_req drop", {63'h0, bus.mem_req}, 64'h0);
            chk("to d_rdata", bus.d_rdata, 64'h0);
            chk("to i_gnt", {63'h0, bus.i_gnt}, 64'h0);
            step();
        end
        bus.d_req = 0; bus.mem_gnt = 1; bus.mem_rdata = 64'h5A;
        @(negedge g_clk);
        chk("post-to i fwd addr", bus.mem_addr, IA);
        chk("post-to i_gnt", {63'h0, bus.i_gnt}, 64'h1);
        chk("post-to i_rdata", bus.i_rdata, 64'h5A);
        step();

        // mem_gnt arriving exactly in the timeout cycle is a normal response.
        bus.i_req = 0; bus.d_req = 1; bus.mem_gnt = 0; bus.mem_rdata = 64'hAB;
        for (int c = 0; c < 5; c++) begin
            @(negedge g_clk);
            chk("race mem_req", {63'h0, bus.mem_req}, 64'h1);
            step();
        end
        bus.mem_gnt = 1;
        @(negedge g_clk);
        chk("race d_gnt", {63'h0, bus.d_gnt}, 64'h1);
        chk("race d_err", {63'h0, bus.d_err}, 64'h0);
        chk("race d_rdata", bus.d_rdata, 64'hAB);
        chk("race mem_req", {63'h0, bus.mem_req}, 64'h1);
        step();
        bus.d_req = 0; bus.mem_gnt = 0;
        @(negedge g_clk);
        chk("race idle after", {63'h0, bus.mem_req}, 64'h0);
        step();

        // Reset while fetch owns the bus.
        bus.i_req = 1;
        @(negedge g_clk);
        chk("rst fwd i", bus.mem_addr, IA);
        step();
        @(negedge g_clk);
        chk("rst own i", {63'h0, bus.mem_req}, 64'h1);
        step();
        g_resetn = 0;
        @(negedge g_clk);
        chk("rst during mem_req", {63'h0, bus.mem_req}, 64'h0);
        chk("rst during i_gnt", {63'h0, bus.i_gnt}, 64'h0);
        step();
        g_resetn = 1; bus.i_req = 0;
        @(negedge g_clk);
        chk("rst after mem_req", {63'h0, bus.mem_req}, 64'h0);
        chk("rst after d_gnt", {63'h0, bus.d_gnt}, 64'h0);
        chk("rst after i_gnt", {63'h0, bus.i_gnt}, 64'h0);
        step();
        bus.d_req = 1; bus.i_req = 1; bus.mem_gnt = 1; bus.mem_rdata = 64'hC3;
        @(negedge g_clk);
        chk("rst first win d_gnt", {63'h0, bus.d_gnt}, 64'h1);
        chk("rst first win i_gnt", {63'h0, bus.i_gnt}, 64'h0);
        chk("rst first win addr", bus.mem_addr, DA);
        step();
        @(negedge g_clk);
        chk("rst second win i_gnt", {63'h0, bus.i_gnt}, 64'h1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
